// File: rtl/cold_storage_pkg.sv
// Shared types for the cold-storage controller: compressor FSM states and alarm codes.
package cold_storage_pkg;

    typedef enum logic [1:0] {
        LOCKOUT = 2'd0,
        OFF     = 2'd1,
        ON      = 2'd2
    } comp_state_t;

    localparam logic [1:0] ALM_NONE  = 2'b00;
    localparam logic [1:0] ALM_OTEMP = 2'b01;
    localparam logic [1:0] ALM_HUM   = 2'b10;
    localparam logic [1:0] ALM_FAULT = 2'b11;

    // Fault outranks over-temp, which outranks humidity.
    function automatic logic [1:0] alm_rank(input logic [1:0] code);
        case (code)
            ALM_FAULT: return 2'd3;
            ALM_OTEMP: return 2'd2;
            ALM_HUM:   return 2'd1;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/cold_storage_ctrl_temp_avg4.sv
// 4-sample moving average of temperature; the first sample after reset fills every slot.
// Output valid the cycle after the sample strobe; no backpressure.
module temp_avg4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample,
    input  logic [7:0] temp_in,
    output logic [7:0] temp_avg
);

    logic [7:0] hist_q [4];
    logic [9:0] sum_q;
    logic       empty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= 8'd0;
            sum_q   <= 10'd0;
            empty_q <= 1'b1;
        end else if (sample) begin
            if (empty_q) begin
                for (int i = 0; i < 4; i++) hist_q[i] <= temp_in;
                sum_q   <= {temp_in, 2'b00};
                empty_q <= 1'b0;
            end else begin
                hist_q[0] <= temp_in;
                for (int i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
                sum_q <= sum_q + {2'b00, temp_in} - {2'b00, hist_q[3]};
            end
        end
    end

    assign temp_avg = sum_q[9:2];

endmodule

// File: rtl/cold_storage_ctrl.sv
// Compressor relay control with hysteresis and min-off lockout, plus latched alarms.
// temp_avg at S+1, relay at S+2, alarm at S+3; no backpressure (samples are never refused).
module cold_storage_ctrl
    import cold_storage_pkg::*;
#(
    parameter int unsigned  CLK_HZ         = 100_000_000,
    parameter logic [7:0]   TEMP_SET       = 8'd4,
    parameter logic [7:0]   TEMP_HYST      = 8'd2,
    parameter logic [7:0]   TEMP_ALARM     = 8'd8,
    parameter logic [7:0]   HUM_MAX        = 8'd85,
    parameter logic [3:0]   ALARM_COUNT    = 4'd3,
    parameter logic [35:0]  MIN_OFF_CYCLES = 36'd18_000_000_000,
    parameter logic [31:0]  TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
    input  logic       data_ready,
    input  logic       alarm_ack,
    output logic [7:0] temp_avg,
    output logic       compressor_on,
    output logic       alarm,
    output logic [1:0] alarm_code,
    output logic       sensor_fault
);

    // Timing constants are cycle counts; the clock rate only documents their origin.
    if (CLK_HZ == 0) begin : g_clk_hz_unset
    end

    logic        dr_q, s_q, sample;
    logic [7:0]  hum_q;
    logic [3:0]  otc, hc;
    logic [31:0] tmo_cnt;
    logic        ot_hit, hum_hit, cause_any, warm, cool;
    logic [1:0]  cause_code;
    comp_state_t state_q, state_d;
    logic [35:0] timer_q, timer_d;

    assign sample = data_ready & ~dr_q;

    temp_avg4 u_avg (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample   (sample),
        .temp_in  (temperature),
        .temp_avg (temp_avg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dr_q         <= 1'b0;
            s_q          <= 1'b0;
            hum_q        <= 8'd0;
            otc          <= 4'd0;
            hc           <= 4'd0;
            tmo_cnt      <= 32'd0;
            sensor_fault <= 1'b0;
        end else begin
            dr_q <= data_ready;
            s_q  <= sample;
            if (sample) hum_q <= humidity;
            // Counters judge the sample one cycle later, once temp_avg includes it.
            if (s_q) begin
                otc <= (temp_avg >= TEMP_ALARM) ? ((otc == 4'hF) ? otc : otc + 4'd1) : 4'd0;
                hc  <= (hum_q > HUM_MAX)        ? ((hc == 4'hF)  ? hc  : hc + 4'd1)  : 4'd0;
            end
            if (sample) begin
                tmo_cnt      <= 32'd0;
                sensor_fault <= 1'b0;
            end else if (tmo_cnt != TIMEOUT_CYCLES) begin
                tmo_cnt      <= tmo_cnt + 32'd1;
                sensor_fault <= (tmo_cnt + 32'd1 == TIMEOUT_CYCLES);
            end
        end
    end

    assign ot_hit    = (otc >= ALARM_COUNT);
    assign hum_hit   = (hc >= ALARM_COUNT);
    assign cause_any = ot_hit | hum_hit | sensor_fault;

    always_comb begin
        cause_code = ALM_NONE;
        if (hum_hit)      cause_code = ALM_HUM;
        if (ot_hit)       cause_code = ALM_OTEMP;
        if (sensor_fault) cause_code = ALM_FAULT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm      <= 1'b0;
            alarm_code <= ALM_NONE;
        end else if (cause_any) begin
            alarm <= 1'b1;
            if (alm_rank(cause_code) > alm_rank(alarm_code)) alarm_code <= cause_code;
        end else if (alarm_ack) begin
            alarm      <= 1'b0;
            alarm_code <= ALM_NONE;
        end
    end

    assign warm = ({1'b0, temp_avg} > ({1'b0, TEMP_SET} + {1'b0, TEMP_HYST}));
    assign cool = (temp_avg <= TEMP_SET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOCKOUT;
            timer_q <= MIN_OFF_CYCLES;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            LOCKOUT: begin
                if (timer_q == 36'd0) state_d = OFF;
                else                  timer_d = timer_q - 36'd1;
            end
            OFF: begin
                if (warm || sensor_fault) state_d = ON;
            end
            ON: begin
                if (cool && !sensor_fault) begin
                    state_d = LOCKOUT;
                    timer_d = MIN_OFF_CYCLES;
                end
            end
            default: begin
                state_d = LOCKOUT;
                timer_d = MIN_OFF_CYCLES;
            end
        endcase
    end

    assign compressor_on = (state_q == ON);

endmodule

// File: doc/cold_storage_ctrl.md
# cold_storage_ctrl

Downstream consumer of the DHT11 reader. It samples each validated humidity/temperature reading, keeps a 4-sample moving average of temperature, and runs the compressor relay FSM with hysteresis and a minimum-off lockout. It also raises latched over-temperature, over-humidity and sensor-timeout alarms for the panel/annunciator logic.

## Interface
- CLK_HZ, 100_000_000, system clock frequency (documentation/derivation only)
- TEMP_SET, 4, setpoint °C, unsigned 8-bit
- TEMP_HYST, 2, hysteresis band °C
- TEMP_ALARM, 8, over-temperature alarm threshold °C
- HUM_MAX, 85, over-humidity threshold %RH
- ALARM_COUNT, 3, consecutive qualifying samples needed to raise an alarm (1..15)
- MIN_OFF_CYCLES, 18_000_000_000, compressor minimum-off time in clk cycles (36-bit counter)
- TIMEOUT_CYCLES, 500_000_000, maximum cycles between valid samples before a sensor fault
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- humidity  in  8  %RH from the reader, valid when data_ready is high
- temperature  in  8  °C from the reader, valid when data_ready is high
- data_ready  in  1  reader valid flag; only the rising edge counts
- alarm_ack  in  1  operator acknowledge, single-cycle pulse
- temp_avg  out  8  moving average of the last 4 samples
- compressor_on  out  1  relay drive
- alarm  out  1  latched alarm
- alarm_code  out  2  00 none, 01 over-temp, 10 over-humidity, 11 sensor fault
- sensor_fault  out  1  no valid sample for TIMEOUT_CYCLES

## Operation
- Sample event S: data_ready is 1 in the current cycle and its registered value is 0. A level held high produces exactly one S.
- Averager: 4-entry shift buffer plus a 10-bit running sum; temp_avg = sum[9:2], truncated.
  - First S after reset fills all 4 entries with that sample.
  - Each later S: sum = sum + new − oldest.
- Compressor FSM:
  - Reset state is LOCKOUT with the timer loaded to MIN_OFF_CYCLES.
  - LOCKOUT: counts down; at 0 → OFF. compressor_on = 0.
  - OFF: → ON when temp_avg > TEMP_SET+TEMP_HYST (9-bit compare), or when sensor_fault = 1.
  - ON: → LOCKOUT (timer reloaded) when temp_avg ≤ TEMP_SET and sensor_fault = 0. compressor_on = 1.
  - Demands arising in LOCKOUT are held off until LOCKOUT expires; they are not remembered, just re-evaluated in OFF.
- Alarm counters: two 4-bit saturating counters, updated only on S+1.
  - otc increments if temp_avg ≥ TEMP_ALARM, else clears.
  - hc increments if humidity > HUM_MAX, else clears.
- Timeout counter: cleared on S; increments otherwise, saturating.
  - On reaching TIMEOUT_CYCLES: sensor_fault = 1.
  - sensor_fault clears on the next S.
- Alarm latch: alarm sets when otc ≥ ALARM_COUNT, hc ≥ ALARM_COUNT, or sensor_fault.
  - alarm_code takes the highest active cause: 11 > 01 > 10. A higher-priority cause overwrites the code while latched.
  - alarm_ack clears alarm and code to 00 only if no cause is active in that cycle; otherwise the ack is ignored.

## Timing
- Reset values: temp_avg 0, compressor_on 0, alarm 0, alarm_code 00, sensor_fault 0, all counters 0, buffer empty flag set. Reset mid-operation aborts everything and re-enters LOCKOUT.
- S detected in cycle E (edge register updated at E). Buffer and sum update at the E+1 edge, so temp_avg is valid from E+1.
- Alarm counters update at E+2. FSM evaluates the new temp_avg at E+2, so compressor_on changes at E+2. alarm sets at E+3.
- Timeout: sensor_fault asserts exactly TIMEOUT_CYCLES cycles after the last S. FSM forcing and alarm each follow one cycle later.
- S and alarm_ack in the same cycle: the ack is evaluated against causes before this sample's update.
- S while the timeout is saturated: sensor_fault clears at E+1; the latched alarm remains until acked.

## Structure
- Shared package/include cold_storage_pkg holds:
  - FSM state encodings: LOCKOUT = 2'd0, OFF = 2'd1, ON = 2'd2.
  - Alarm code constants: ALM_NONE, ALM_OTEMP, ALM_HUM, ALM_FAULT.
- One sub-module, temp_avg4: averager with sample strobe in, temp_avg out, first-fill logic inside.
- FSM, counters and alarm latch stay in the top module.

## Test plan
All scenarios use MIN_OFF_CYCLES=50 and TIMEOUT_CYCLES=1000.
- Reset, wait 50 cycles, then pulse temperature=10 → temp_avg=10 at E+1; compressor_on=1 at E+2.
- While ON, 4 samples of temperature=3 → temp_avg reaches 3 after the 4th; compressor_on=0; it stays 0 for 50 cycles even with a temperature=20 sample inside the window, then rises within 1 cycle after LOCKOUT ends.
- Three samples with temperature=9 → alarm=1, code 01, after the 3rd; alarm_ack while still 9 → no change; samples of 2 then alarm_ack → alarm=0, code 00.
- humidity=90 ×3 with temperature=4 → alarm code 10; then 1000 idle cycles → sensor_fault=1, code 11, compressor forced on after LOCKOUT.
- data_ready held high for 20 cycles → exactly one sample consumed (buffer shifts once).
- Assert rst_n low mid-LOCKOUT and mid-alarm → all outputs return to reset values immediately (asynchronously).
